// File: rtl/ipsxb_uart_cmd_master_32bit.sv
// Host-side UART control-protocol initiator: serialises write/read requests into
// command frames and reassembles 4-byte read replies into 32-bit words.
module ipsxb_uart_cmd_master_32bit #(
    parameter logic [7:0]  CMD_WR      = 8'h57,
    parameter logic [7:0]  CMD_RD      = 8'h52,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [8:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t      state_reg, state_next;

    logic        wr_reg;
    logic [8:0]  addr_reg;
    logic [31:0] wdata_reg;
    logic [2:0]  idx_reg;
    logic [1:0]  rx_cnt_reg;
    logic [31:0] asm_reg;
    logic [31:0] to_cnt_reg;

    logic        cmd_ready_reg, cmd_ready_next;
    logic        tx_valid_reg, tx_valid_next;
    logic [7:0]  tx_data_reg, tx_data_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_rdata_reg, rsp_rdata_next;
    logic        rsp_timeout_reg, rsp_timeout_next;

    logic        accept;
    logic        tx_fire;
    logic        last_byte;
    logic        rx_take;
    logic        rx_last;
    logic        to_expire;

    function automatic logic [7:0] frame_byte(
        input logic [2:0]  idx,
        input logic        wr,
        input logic [8:0]  addr,
        input logic [31:0] wdata
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = wr ? CMD_WR : CMD_RD;
            3'd1:    b = {7'b0, addr[8]};
            3'd2:    b = addr[7:0];
            3'd3:    b = wdata[31:24];
            3'd4:    b = wdata[23:16];
            3'd5:    b = wdata[15:8];
            3'd6:    b = wdata[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign accept    = (state_reg == ST_IDLE) && cmd_valid && cmd_ready_reg;
    assign tx_fire   = tx_valid_reg && tx_ready;
    assign last_byte = (idx_reg == (wr_reg ? 3'd6 : 3'd2));
    assign rx_take   = (state_reg == ST_WAIT_RSP) && rx_valid;
    assign rx_last   = rx_take && (rx_cnt_reg == 2'd3);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign to_expire = (state_reg == ST_WAIT_RSP) && !rx_valid &&
                       (TIMEOUT_CYC != 32'd0) &&
                       (to_cnt_reg == TIMEOUT_CYC - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_SEND;
            end
            ST_SEND: begin
                if (tx_fire && last_byte) state_next = wr_reg ? ST_DONE : ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (rx_last || to_expire) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy             = (state_reg != ST_IDLE);
        cmd_ready_next   = (state_next == ST_IDLE);
        tx_valid_next    = (state_next == ST_SEND);
        rsp_valid_next   = (state_next == ST_DONE);
        tx_data_next     = tx_data_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_timeout_next = rsp_timeout_reg;

        // The first byte comes straight from the request; later bytes from the latched copy.
        if (accept) begin
            tx_data_next = frame_byte(3'd0, cmd_wr, cmd_addr, cmd_wdata);
        end else if (tx_fire && !last_byte) begin
            tx_data_next = frame_byte(idx_reg + 3'd1, wr_reg, addr_reg, wdata_reg);
        end

        if (state_next == ST_DONE) begin
            if (rx_last) begin
                rsp_rdata_next   = {asm_reg[23:0], rx_data};
                rsp_timeout_next = 1'b0;
            end else if (to_expire) begin
                rsp_rdata_next   = 32'h0;
                rsp_timeout_next = 1'b1;
            end else begin
                rsp_rdata_next   = 32'h0;
                rsp_timeout_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_reg          <= 1'b0;
            addr_reg        <= 9'h0;
            wdata_reg       <= 32'h0;
            idx_reg         <= 3'd0;
            rx_cnt_reg      <= 2'd0;
            asm_reg         <= 32'h0;
            to_cnt_reg      <= 32'h0;
            cmd_ready_reg   <= 1'b0;
            tx_valid_reg    <= 1'b0;
            tx_data_reg     <= 8'h00;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= 32'h0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            cmd_ready_reg   <= cmd_ready_next;
            tx_valid_reg    <= tx_valid_next;
            tx_data_reg     <= tx_data_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_timeout_reg <= rsp_timeout_next;

            if (accept) begin
                wr_reg    <= cmd_wr;
                addr_reg  <= cmd_addr;
                wdata_reg <= cmd_wdata;
                idx_reg   <= 3'd0;
            end else if (tx_fire) begin
                idx_reg <= idx_reg + 3'd1;
            end

            if ((state_reg == ST_SEND) && (state_next == ST_WAIT_RSP)) begin
                rx_cnt_reg <= 2'd0;
                asm_reg    <= 32'h0;
                to_cnt_reg <= 32'h0;
            end else if (rx_take) begin
                asm_reg    <= {asm_reg[23:0], rx_data};
                rx_cnt_reg <= rx_cnt_reg + 2'd1;
                to_cnt_reg <= 32'h0;
            end else if (state_reg == ST_WAIT_RSP) begin
                to_cnt_reg <= to_cnt_reg + 32'd1;
            end
        end
    end

    assign cmd_ready   = cmd_ready_reg;
    assign tx_valid    = tx_valid_reg;
    assign tx_data     = tx_data_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_timeout = rsp_timeout_reg;

endmodule
